// File: rtl/sb_frame_tx.sv
// Sideband frame transmitter: serialises bytes as 10-bit start/data/stop symbols
// and closes each frame with two CRC-16 (0x8005, init 0xFFFF) symbols and an idle gap.
module sb_frame_tx #(
    parameter int unsigned GAP_BITS = 2
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       trans_ser,
    output logic       crc_en,
    output logic       busy,
    output logic       tx_done,
    output logic       err_underrun
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CRC_W  = 16;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(9);
    localparam logic [IDX_W-1:0] GAP_END  = IDX_W'(GAP_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sym_q, sym_d;
    logic [IDX_W-1:0]   gap_q, gap_d;
    logic [7:0]         byte_q, byte_d;
    logic               last_q, last_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic               ser_q, ser_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic              fb;
        logic [CRC_W-1:0]  n;
        fb    = c[15] ^ b;
        n     = {c[14:0], fb};
        n[2]  = c[1] ^ fb;
        n[15] = c[14] ^ fb;
        return n;
    endfunction

    // Handshake and underrun flag are decoded from registered state only (plus the offer itself).
    assign in_ready     = !rst && ((state_q == S_IDLE) ||
                                   (state_q == S_DATA && idx_q == IDX_LAST && !last_q));
    assign err_underrun = !rst && state_q == S_DATA && idx_q == IDX_LAST && !last_q && !in_valid;

    assign trans_ser = ser_q;
    assign crc_en    = en_q;
    assign busy      = busy_q;
    assign tx_done   = done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sym_d   = sym_q;
        gap_d   = gap_q;
        byte_d  = byte_q;
        last_d  = last_q;
        crc_d   = crc_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    byte_d  = in_data;
                    last_d  = in_last;
                    crc_d   = 16'hFFFF;
                end
            end
            S_DATA: begin
                // ser_q holds the data bit currently on the line
                if (idx_q >= IDX_W'(1) && idx_q <= IDX_W'(8)) begin
                    crc_d = crc_step(crc_q, ser_q);
                end
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    if (!last_q && in_valid) begin
                        byte_d = in_data;
                        last_d = in_last;
                    end else begin
                        state_d = S_CRC;
                        sym_d   = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_CRC: begin
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    if (sym_q) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        sym_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_END) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line bit for the cycle being entered; CRC snapshot is crc_d, frozen outside DATA.
        ser_d = 1'b1;
        case (state_d)
            S_DATA: begin
                if (idx_d == '0) begin
                    ser_d = 1'b0;
                end else if (idx_d <= IDX_W'(8)) begin
                    ser_d = byte_d[3'(idx_d - IDX_W'(1))];
                end
            end
            S_CRC: begin
                if (idx_d == '0) begin
                    ser_d = 1'b0;
                end else if (idx_d <= IDX_W'(8)) begin
                    ser_d = sym_d ? crc_d[4'(IDX_W'(8) - idx_d)]
                                  : crc_d[4'(5'd16 - 5'(idx_d))];
                end
            end
            default: ser_d = 1'b1;
        endcase
        en_d   = (state_d == S_DATA) || (state_d == S_CRC);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sym_q   <= 1'b0;
            gap_q   <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            crc_q   <= 16'hFFFF;
            ser_q   <= 1'b1;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sym_q   <= sym_d;
            gap_q   <= gap_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            crc_q   <= crc_d;
            ser_q   <= ser_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sb_frame_tx.sv
// Directed bench for sb_frame_tx: line monitor with a CRC-16 residue checker.
module tb_sb_frame_tx;

    localparam int unsigned GAP = 2;

    logic       sb_clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       trans_ser;
    logic       crc_en;
    logic       busy;
    logic       tx_done;
    logic       err_underrun;

    sb_frame_tx #(.GAP_BITS(GAP)) dut (
        .sb_clk       (sb_clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .trans_ser    (trans_ser),
        .crc_en       (crc_en),
        .busy         (busy),
        .tx_done      (tx_done),
        .err_underrun (err_underrun)
    );

    always #5 sb_clk = ~sb_clk;

    int cyc = 0;
    always @(posedge sb_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        logic msb;
        msb = c[15] ^ b;
        c   = c << 1;
        if (msb) c = c ^ 16'h8005;
        return c;
    endfunction

    // Line monitor, sampled mid-cycle on the falling edge.
    logic bits[$];
    logic last_bits[$];
    int   en_len = 0, last_len = 0, gap_len = 0, tx_cnt = 0, ur_cnt = 0;
    int   tx_cyc = 0, ur_cyc = 0, first_en_cyc = 0, rdy_bad = 0, gap_bad = 0;
    logic en_prev = 1'b0;

    always @(negedge sb_clk) begin
        if (crc_en === 1'b1) begin
            if (en_prev !== 1'b1) first_en_cyc = cyc;
            bits.push_back(trans_ser);
            if (in_ready && (en_len % 10) != 9) rdy_bad++;
            en_len++;
        end else begin
            if (en_prev === 1'b1) begin
                last_bits = bits;
                last_len  = en_len;
                bits.delete();
                en_len = 0;
            end
            if (busy === 1'b1) begin
                gap_len++;
                if (trans_ser !== 1'b1) gap_bad++;
            end
        end
        if (tx_done === 1'b1) begin tx_cnt++; tx_cyc = cyc; end
        if (err_underrun === 1'b1) begin ur_cnt++; ur_cyc = cyc; end
        en_prev = crc_en;
    end

    logic [7:0] sent[$];
    int tx0, ur0, gap0, rdy0, gbad0;

    task automatic tick();
        @(posedge sb_clk);
        #1;
    endtask

    task automatic base();
        sent.delete();
        tx0 = tx_cnt; ur0 = ur_cnt; gap0 = gap_len; rdy0 = rdy_bad; gbad0 = gap_bad;
    endtask

    task automatic push(input logic [7:0] b, input logic l, output int acc);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = b; in_last = l;
        while (!in_ready && n < 400) begin tick(); n++; end
        chk("push_wait", 32'(n < 400), 1);
        acc = cyc;
        sent.push_back(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin tick(); n++; end
        chk("idle_wait", 32'(busy), 0);
    endtask

    task automatic check_frame(input int nbytes);
        logic [15:0] r, m, rx;
        int ferr;
        chk("frame_len", last_len, 10 * (nbytes + 2));
        if (last_bits.size() == 10 * (nbytes + 2)) begin
            ferr = 0; r = 16'hFFFF; rx = '0;
            for (int s = 0; s < nbytes + 2; s++) begin
                if (last_bits[10*s] !== 1'b0 || last_bits[10*s+9] !== 1'b1) ferr++;
                for (int k = 1; k <= 8; k++) begin
                    r = crc_bit(r, last_bits[10*s+k]);
                    if (s >= nbytes) rx = {rx[14:0], last_bits[10*s+k]};
                end
            end
            m = 16'hFFFF;
            foreach (sent[i]) for (int k = 0; k < 8; k++) m = crc_bit(m, sent[i][k]);
            chk("framing", ferr, 0);
            chk("residue", r, 0);
            chk("crc_word", rx, m);
        end
    endtask

    initial begin
        int a, a2, a3, b;
        logic [9:0] sym;
        logic [7:0] bb;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) tick();
        chk("rst_ser", trans_ser, 1);
        chk("rst_en", crc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ur", err_underrun, 0);
        chk("rst_rdy", in_ready, 0);
        rst = 1'b0;
        tick();
        chk("idle_rdy", in_ready, 1);
        chk("idle_ser", trans_ser, 1);

        // single byte 0xA5
        base();
        push(8'hA5, 1'b1, a);
        wait_idle();
        chk("a5_first_bit", first_en_cyc - a, 1);
        sym = '0;
        for (int i = 0; i < 10 && i < last_bits.size(); i++) sym = {sym[8:0], last_bits[i]};
        chk("a5_symbol", sym, 10'b0101001011);
        check_frame(1);
        chk("a5_done_cyc", tx_cyc - a, 31);
        chk("a5_done_cnt", tx_cnt - tx0, 1);
        chk("a5_ur_cnt", ur_cnt - ur0, 0);

        // three back-to-back bytes
        base();
        push(8'h01, 1'b0, a);
        push(8'h02, 1'b0, a2);
        push(8'h03, 1'b1, a3);
        wait_idle();
        chk("b3_acc2", a2 - a, 10);
        chk("b3_acc3", a3 - a2, 10);
        check_frame(3);
        chk("b3_rdy_idx", rdy_bad - rdy0, 0);
        chk("b3_done_cnt", tx_cnt - tx0, 1);
        chk("b3_ur_cnt", ur_cnt - ur0, 0);

        // underrun after first byte
        base();
        push(8'h5A, 1'b0, a);
        wait_idle();
        chk("ur_cnt", ur_cnt - ur0, 1);
        chk("ur_cyc", ur_cyc - a, 10);
        check_frame(1);
        chk("ur_done_cnt", tx_cnt - tx0, 1);
        chk("ur_done_cyc", tx_cyc - a, 31);

        // back-to-back frames, second offer held through CRC/GAP
        base();
        push(8'h3C, 1'b1, a);
        push(8'hC3, 1'b1, b);
        bb = sent.pop_back();
        check_frame(1);
        chk("b2b_acc", b - a, 31 + GAP);
        chk("b2b_gap_len", gap_len - gap0, GAP);
        sent.delete();
        sent.push_back(bb);
        wait_idle();
        check_frame(1);
        chk("b2b_gap_ser", gap_bad - gbad0, 0);
        chk("b2b_done_cnt", tx_cnt - tx0, 2);

        // reset at symbol 2 index 4
        base();
        push(8'h77, 1'b0, a);
        push(8'h88, 1'b1, a2);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("mrst_ser", trans_ser, 1);
        chk("mrst_en", crc_en, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", tx_done, 0);
        chk("mrst_rdy", in_ready, 0);
        rst = 1'b0;
        repeat (40) tick();
        chk("mrst_done_cnt", tx_cnt - tx0, 0);
        chk("mrst_ur_cnt", ur_cnt - ur0, 0);
        chk("mrst_idle", in_ready, 1);
        base();
        push(8'hE7, 1'b1, a);
        wait_idle();
        check_frame(1);
        chk("post_done_cnt", tx_cnt - tx0, 1);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sb_frame_tx.md
SB_FRAME_TX -- requirements
Module: sb_frame_tx

Interface
REQ-001 Parameter: GAP_BITS, default 2, idle bit-times between frames (crc_en=0); legal range 1..15.
REQ-002 sb_clk  input  1  sideband bit clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_data  input  8  payload byte offered by upstream.
REQ-005 in_valid  input  1  in_data/in_last valid.
REQ-006 in_last  input  1  marks the final payload byte of a frame.
REQ-007 in_ready  output  1  byte accepted on a cycle with in_valid && in_ready.
REQ-008 trans_ser  output  1  serial line to the downstream CRC-16 checker.
REQ-009 crc_en  output  1  high on every bit-time of a frame (data and CRC symbols), low otherwise.
REQ-010 busy  output  1  high from the first frame bit through the last GAP cycle.
REQ-011 tx_done  output  1  one-cycle pulse, frame completed normally or by underrun.
REQ-012 err_underrun  output  1  one-cycle pulse, mid-frame byte not available at a symbol boundary.

Function
REQ-013 States: IDLE, DATA, CRC, GAP; 4-bit bit index 0..9 within each 10-bit symbol; 1-bit CRC-symbol counter.
REQ-014 Symbol format, transmit order: index 0 start bit = 0, indices 1..8 data bits, index 9 stop bit = 1.
REQ-015 DATA symbols shall send payload LSB first (index 1 = d0 ... index 8 = d7).
REQ-016 IDLE: in_ready=1, trans_ser=1, crc_en=0, busy=0; accepted byte at cycle T -> its index-0 bit is driven at T+1 and state becomes DATA.
REQ-017 trans_ser and crc_en shall be registered outputs; no combinational path from inputs to them.
REQ-018 CRC: 16-bit register, init 16'hFFFF at frame start, polynomial x^16+x^15+x^2+1, MSB-first shift; fb = crc[15] ^ bit; next = {crc[14:0],fb} with bit 2 = crc[1]^fb and bit 15 = crc[14]^fb.
REQ-019 CRC shall update only on data-bit cycles (index 1..8) of DATA symbols; start/stop bits and CRC symbols excluded.
REQ-020 In DATA, in_ready=1 only on index-9 cycles of a symbol whose byte had in_last=0; accept -> next symbol index 0 on the following cycle (no gap, crc_en stays high).
REQ-021 Index 9 of a symbol with in_last=1 -> next cycle enters CRC.
REQ-022 Underrun: index 9, in_last=0, no accept -> err_underrun=1 that cycle, next cycle enters CRC; frame closed with CRC over bytes sent.
REQ-023 CRC state: snapshot C of the CRC register on entry; two symbols with standard start/stop; data bits in transmit order C[15],C[14],...,C[8], then C[7],...,C[0]. Downstream residue is zero.
REQ-024 After CRC symbol 2 index 9 -> GAP; tx_done=1 on the first GAP cycle only.
REQ-025 GAP: GAP_BITS cycles, trans_ser=1, crc_en=0, in_ready=0, busy=1; then IDLE.
REQ-026 in_ready=0 in CRC and GAP and at every DATA index 0..8; in_valid during those cycles is ignored and shall not be consumed.
REQ-027 Frame length unbounded; each data symbol occupies exactly 10 crc_en cycles.
REQ-028 A frame of N bytes shall hold crc_en=1 for exactly 10*(N+2) contiguous cycles.

Reset
REQ-029 rst=1 at a rising edge: state IDLE, bit index 0, CRC 16'hFFFF, trans_ser=1, crc_en=0, busy=0, tx_done=0, err_underrun=0; in_ready=0 while rst=1.
REQ-030 Reset mid-frame aborts it at once: no CRC symbols, no tx_done, no err_underrun; first post-reset cycle is IDLE.

Verification
REQ-031 Single byte 0xA5, in_last=1 -> trans_ser 0,1,0,1,0,0,1,0,1,1 at T+1..T+10; 20 CRC bits follow; crc_en high 30 cycles; tx_done at T+31; checker residue 0, no error.
REQ-032 Three back-to-back bytes 0x01,0x02,0x03 (last on 0x03) -> in_ready only on index-9 cycles; crc_en high 50 contiguous cycles; residue 0.
REQ-033 Two-byte frame, in_valid dropped before byte 2 -> err_underrun at first symbol index 9; CRC over byte 1 only; crc_en high 30 cycles; tx_done pulses once.
REQ-034 Back-to-back frames, GAP_BITS=2 -> exactly 2 cycles crc_en=0/trans_ser=1 between frames, then in_ready=1; second frame CRC restarts from 16'hFFFF.
REQ-035 rst=1 at symbol 2 index 4 -> next cycle trans_ser=1, crc_en=0, busy=0, no tx_done; a following 1-byte frame is correct.
REQ-036 in_valid held during CRC/GAP -> byte not consumed until IDLE in_ready=1.
